// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one input bit per cycle.
// It produces packed BCD digits, an overflow flag and a leading-zero blank mask for the display.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DIGITS*4-1:0]   o_bcd,
  output logic                  o_overflow,
  output logic [DIGITS-1:0]     o_lz_mask,
  output logic                  o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] LZ_RESET = {DIGITS{1'b1}} << 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]          state;
  logic [WIDTH-1:0]    bin_r;
  logic [DIGITS*4-1:0] bcd_r;
  logic                carry_r;
  logic [CW-1:0]       cnt;

  logic [DIGITS*4-1:0] adj_bcd;
  logic [DIGITS*4-1:0] shift_bcd;
  logic                shift_carry;
  logic [DIGITS-1:0]   lz_next;
  logic [3:0]          digit;
  logic                all_zero;

  // Handshake: a transfer happens on a rising edge where i_valid && o_ready.
  // o_valid is a single-cycle pulse with no back-pressure; results are held until the next one.
  assign o_ready     = (state == ST_IDLE) && !i_rst;
  assign o_dbg_state = state[0];

  always_comb begin
    adj_bcd  = '0;
    digit    = '0;
    lz_next  = '0;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = bcd_r[4*i +: 4];
      adj_bcd[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
    shift_bcd   = {adj_bcd[DIGITS*4-2:0], bin_r[WIDTH-1]};
    shift_carry = adj_bcd[DIGITS*4-1];
    // Digit i is blank only if it and every digit above it are zero; the units digit always shows.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero   = all_zero && (shift_bcd[4*i +: 4] == 4'd0);
      lz_next[i] = all_zero;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      bin_r      <= '0;
      bcd_r      <= '0;
      carry_r    <= 1'b0;
      cnt        <= '0;
      o_valid    <= 1'b0;
      o_bcd      <= '0;
      o_overflow <= 1'b0;
      o_lz_mask  <= LZ_RESET;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            bin_r   <= i_data;
            bcd_r   <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bin_r   <= bin_r << 1;
          bcd_r   <= shift_bcd;
          carry_r <= carry_r | shift_carry;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            o_bcd      <= shift_bcd;
            o_overflow <= carry_r | shift_carry;
            o_lz_mask  <= lz_next;
            o_valid    <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
